// File: rtl/sram_sync_param_if.sv
// Bus bundle for sram_sync_param: access strobes, address/data/mask in,
// registered read data and status pulses out.
interface sram_sync_param_if #(
    parameter int DW = 8,
    parameter int AW = 10
);
    logic          ce_n;
    logic          we_n;
    logic [AW-1:0] addr;
    logic [DW-1:0] di;
    logic [DW-1:0] wmask;
    logic [DW-1:0] dout;
    logic          dout_vld;
    logic          init_busy;
    logic          addr_err;

    modport master (
        output ce_n, we_n, addr, di, wmask,
        input  dout, dout_vld, init_busy, addr_err
    );

    modport slave (
        input  ce_n, we_n, addr, di, wmask,
        output dout, dout_vld, init_busy, addr_err
    );
endinterface

// File: rtl/sram_sync_param.sv
// Parametrised synchronous single-port RAM with per-bit write mask, selectable
// write-cycle read mode, registered read with valid strobe and post-reset clear sweep.
module sram_sync_param #(
    parameter int            DW           = 8,
    parameter int            AW           = 10,
    parameter int            DEPTH        = 1024,
    parameter int            READ_MODE    = 0,
    parameter int            CLEAR_ON_RST = 1,
    parameter logic [DW-1:0] INIT_VAL     = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    sram_sync_param_if.slave  bus
);

    localparam int            IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_LIM = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST      = AW'(DEPTH - 1);

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] ctr_q, ctr_d;
    logic          sweep_we;

    logic [DW-1:0] mem [DEPTH];

    logic          addr_ok;
    logic          we_x;
    logic          access;
    logic          bad;
    logic          do_read;
    logic          do_write;
    logic [IW-1:0] idx;
    logic [IW-1:0] ctr_idx;
    logic [DW-1:0] old_word;
    logic [DW-1:0] new_word;

    logic [DW-1:0] dout_p1;
    logic          vld_p1;
    logic          err_p1;

    function automatic logic [DW-1:0] merge_word(
        input logic [DW-1:0] old,
        input logic [DW-1:0] din,
        input logic [DW-1:0] mask
    );
        return (old & ~mask) | (din & mask);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_READY;
            ctr_q   <= '0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
        end
    end

    // Sweep writes one word per clock; the last word hands over to READY.
    always_comb begin
        state_d  = state_q;
        ctr_d    = ctr_q;
        sweep_we = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                sweep_we = 1'b1;
                if (ctr_q == LAST) begin
                    state_d = ST_READY;
                    ctr_d   = '0;
                end else begin
                    ctr_d = ctr_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
    end

    // Unknown or out-of-range addresses and an unknown we_n become error accesses.
    always_comb begin
        addr_ok = 1'b0;
        if (!$isunknown(bus.addr))
            addr_ok = ({1'b0, bus.addr} < DEPTH_LIM);
        we_x     = $isunknown(bus.we_n);
        access   = (state_q == ST_READY) && (bus.ce_n == 1'b0);
        bad      = access && (!addr_ok || we_x);
        do_read  = access && addr_ok && !we_x && (bus.we_n == 1'b1);
        do_write = access && addr_ok && !we_x && (bus.we_n == 1'b0);
        idx      = bus.addr[IW-1:0];
        ctr_idx  = ctr_q[IW-1:0];
        old_word = addr_ok ? mem[idx] : '0;
        new_word = merge_word(old_word, bus.di, bus.wmask);
    end

    always_ff @(posedge clk) begin
        if (sweep_we)
            mem[ctr_idx] <= INIT_VAL;
        else if (do_write)
            mem[idx] <= new_word;
    end

    // Stage p1: registered read port
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout_p1 <= '0;
            vld_p1  <= 1'b0;
            err_p1  <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            err_p1 <= 1'b0;
            if (bad) begin
                dout_p1 <= '0;
                vld_p1  <= 1'b1;
                err_p1  <= 1'b1;
            end else if (do_read) begin
                dout_p1 <= old_word;
                vld_p1  <= 1'b1;
            end else if (do_write) begin
                if (READ_MODE == 0) begin
                    dout_p1 <= old_word;
                    vld_p1  <= 1'b1;
                end else if (READ_MODE == 1) begin
                    dout_p1 <= new_word;
                    vld_p1  <= 1'b1;
                end
            end
        end
    end

    assign bus.dout      = dout_p1;
    assign bus.dout_vld  = vld_p1;
    assign bus.addr_err  = err_p1;
    assign bus.init_busy = (state_q == ST_CLEAR);

endmodule
